// File: rtl/traffic_pkg.sv
// Shared types and lamp constants for the
// two-road traffic phase scheduler.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_G1    = 3'd0,
    ST_Y1    = 3'd1,
    ST_AR1   = 3'd2,
    ST_G2    = 3'd3,
    ST_Y2    = 3'd4,
    ST_AR2   = 3'd5,
    ST_EMERG = 3'd6
  } state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam logic ROAD1 = 1'b0;
  localparam logic ROAD2 = 1'b1;

endpackage

// File: rtl/tl_phase_timer.sv
// Loadable down-counter for phase timing:
// steps on tick, holds while frozen, flags zero.
module tl_phase_timer #(
  parameter int            TW      = 5,
  parameter logic [TW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          tick,
  input  logic          freeze,
  output logic [TW-1:0] count,
  output logic          zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (tick && !freeze && !zero) begin
      count <= count - TW'(1);
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection phase controller with
// latched pedestrian requests and emergency preemption.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int GREEN_T   = 15,
  parameter int YELLOW_T  = 5,
  parameter int ALLRED_T  = 2,
  parameter int MIN_GREEN = 5,
  parameter int WALK_T    = 4,
  parameter int TW        = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ped_req1,
  input  logic       ped_req2,
  input  logic       emerg_req,
  input  logic       emerg_dir,
  output logic [2:0] out1,
  output logic [2:0] out2,
  output logic       walk1,
  output logic       walk2,
  output logic [2:0] phase
);

  state_t          state, state_n;
  logic            edir, edir_n;
  logic            pend1, pend2;
  logic            pe1, pe2;
  logic            enter;
  logic            trunc_ok;
  logic [TW-1:0]   timer, load_val;
  logic            tzero;
  logic [TW-1:0]   wcnt;

  assign pe1      = pend1 | ped_req1;
  assign pe2      = pend2 | ped_req2;
  assign trunc_ok = (timer <= TW'(GREEN_T - MIN_GREEN));
  assign enter    = (state_n != state);
  assign phase    = state;

  tl_phase_timer #(
    .TW      (TW),
    .RST_VAL (TW'(GREEN_T - 1))
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (enter),
    .load_val (load_val),
    .tick     (tick),
    .freeze   (state == ST_EMERG),
    .count    (timer),
    .zero     (tzero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_G1;
      edir  <= ROAD1;
    end else begin
      state <= state_n;
      edir  <= edir_n;
    end
  end

  always_comb begin
    state_n  = state;
    edir_n   = edir;
    load_val = '0;
    unique case (state)
      ST_G1: begin
        if (emerg_req && emerg_dir == ROAD1) begin
          state_n = ST_EMERG;
          edir_n  = ROAD1;
        end else if (tick && (emerg_req || tzero || (pe1 && trunc_ok))) begin
          state_n = ST_Y1;
        end
      end
      ST_Y1:
        if (tick && tzero) state_n = ST_AR1;
      ST_AR1: begin
        if (tick && tzero) begin
          if (emerg_req) begin
            state_n = ST_EMERG;
            edir_n  = emerg_dir;
          end else begin
            state_n = ST_G2;
          end
        end
      end
      ST_G2: begin
        if (emerg_req && emerg_dir == ROAD2) begin
          state_n = ST_EMERG;
          edir_n  = ROAD2;
        end else if (tick && (emerg_req || tzero || (pe2 && trunc_ok))) begin
          state_n = ST_Y2;
        end
      end
      ST_Y2:
        if (tick && tzero) state_n = ST_AR2;
      ST_AR2: begin
        if (tick && tzero) begin
          if (emerg_req) begin
            state_n = ST_EMERG;
            edir_n  = emerg_dir;
          end else begin
            state_n = ST_G1;
          end
        end
      end
      ST_EMERG:
        if (!emerg_req) state_n = (edir == ROAD1) ? ST_Y1 : ST_Y2;
      default: state_n = ST_G1;
    endcase
    unique case (state_n)
      ST_G1, ST_G2:   load_val = TW'(GREEN_T - 1);
      ST_Y1, ST_Y2:   load_val = TW'(YELLOW_T - 1);
      ST_AR1, ST_AR2: load_val = TW'(ALLRED_T - 1);
      default:        load_val = '0;
    endcase
  end

  // Walk is only granted on green entry and always drops on green exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend1 <= 1'b0;
      pend2 <= 1'b0;
      walk1 <= 1'b0;
      walk2 <= 1'b0;
      wcnt  <= '0;
    end else begin
      pend1 <= pe1;
      pend2 <= pe2;
      if (enter && state_n == ST_G2 && pe1) begin
        pend1 <= 1'b0;
        walk1 <= 1'b1;
        wcnt  <= TW'(WALK_T - 1);
      end else if (enter && state_n == ST_G1 && pe2) begin
        pend2 <= 1'b0;
        walk2 <= 1'b1;
        wcnt  <= TW'(WALK_T - 1);
      end else if (enter) begin
        walk1 <= 1'b0;
        walk2 <= 1'b0;
      end else if (tick && (walk1 || walk2)) begin
        if (wcnt == '0) begin
          walk1 <= 1'b0;
          walk2 <= 1'b0;
        end else begin
          wcnt <= wcnt - TW'(1);
        end
      end
    end
  end

  always_comb begin
    out1 = RED;
    out2 = RED;
    unique case (state)
      ST_G1:    out1 = GRN;
      ST_Y1:    out1 = YEL;
      ST_G2:    out2 = GRN;
      ST_Y2:    out2 = YEL;
      ST_EMERG: begin
        out1 = (edir == ROAD1) ? GRN : RED;
        out2 = (edir == ROAD2) ? GRN : RED;
      end
      default: begin
        out1 = RED;
        out2 = RED;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed and random checks of the phase scheduler
// against a tick-counting reference model.
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       ped_req1, ped_req2;
  logic       emerg_req, emerg_dir;
  logic [2:0] out1, out2, phase;
  logic       walk1, walk2;

  int total = 0;
  int bad   = 0;

  int m_ph, m_el, m_w1, m_w2;
  bit m_p1, m_p2, m_ed;

  always #5 clk = ~clk;

  traffic_phase_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .ped_req1  (ped_req1),
    .ped_req2  (ped_req2),
    .emerg_req (emerg_req),
    .emerg_dir (emerg_dir),
    .out1      (out1),
    .out2      (out2),
    .walk1     (walk1),
    .walk2     (walk2),
    .phase     (phase)
  );

  // Phases 0..5 = G1,Y1,AR1,G2,Y2,AR2; 6 = emergency hold.
  function automatic int dur(input int p);
    case (p)
      0, 3:    return 15;
      1, 4:    return 5;
      default: return 2;
    endcase
  endfunction

  function automatic logic [2:0] e_out1();
    case (m_ph)
      0:       return 3'b001;
      1:       return 3'b010;
      6:       return m_ed ? 3'b100 : 3'b001;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] e_out2();
    case (m_ph)
      3:       return 3'b001;
      4:       return 3'b010;
      6:       return m_ed ? 3'b001 : 3'b100;
      default: return 3'b100;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = 0; m_el = 0; m_w1 = 0; m_w2 = 0;
    m_p1 = 0; m_p2 = 0; m_ed = 0;
  endtask

  task automatic model_step();
    bit e1, e2, ne, ped;
    int nph, road;
    e1 = m_p1 | ped_req1;
    e2 = m_p2 | ped_req2;
    nph = m_ph;
    ne = m_ed;
    if (m_ph == 0 || m_ph == 3) begin
      road = (m_ph == 0) ? 0 : 1;
      ped = (m_ph == 0) ? e1 : e2;
      if (emerg_req && int'(emerg_dir) == road) begin
        nph = 6;
        ne = emerg_dir;
      end else if (tick) begin
        if (m_el + 1 >= 15 || emerg_req || (ped && m_el + 1 >= 5))
          nph = m_ph + 1;
        else
          m_el++;
      end
    end else if (m_ph == 6) begin
      if (!emerg_req) nph = m_ed ? 4 : 1;
    end else if (tick) begin
      if (m_el + 1 >= dur(m_ph)) begin
        if ((m_ph == 2 || m_ph == 5) && emerg_req) begin
          nph = 6;
          ne = emerg_dir;
        end else begin
          nph = (m_ph + 1) % 6;
        end
      end else begin
        m_el++;
      end
    end
    if (nph != m_ph) begin
      m_w1 = 0; m_w2 = 0; m_el = 0;
    end else if (tick && (m_ph == 0 || m_ph == 3)) begin
      if (m_w1 > 0) m_w1--;
      if (m_w2 > 0) m_w2--;
    end
    m_p1 = e1;
    m_p2 = e2;
    if (nph != m_ph && nph == 3 && e1) begin m_p1 = 0; m_w1 = 4; end
    if (nph != m_ph && nph == 0 && e2) begin m_p2 = 0; m_w2 = 4; end
    m_ph = nph;
    m_ed = ne;
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("out1", out1, e_out1());
    chk("out2", out2, e_out2());
    chk("walk1", {2'b0, walk1}, {2'b0, m_w1 > 0});
    chk("walk2", {2'b0, walk2}, {2'b0, m_w2 > 0});
  endtask

  task automatic cyc(input bit t);
    tick = t;
    @(posedge clk);
    model_step();
    #1;
    chk_model();
    tick = 1'b0;
  endtask

  task automatic tk(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0); cyc(0); cyc(0); cyc(1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_out1", out1, 3'b001);
    chk("rst_out2", out2, 3'b100);
    chk("rst_walk", {1'b0, walk1, walk2}, 3'b000);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 0;
    ped_req1 = 0; ped_req2 = 0;
    emerg_req = 0; emerg_dir = 0;
    model_reset();
    #2;
    chk("por_out1", out1, 3'b001);
    chk("por_out2", out2, 3'b100);
    chk("por_walk", {1'b0, walk1, walk2}, 3'b000);
    @(posedge clk);
    #1;
    reset = 1'b0;

    tk(14); chk("s1_g1", out1, 3'b001);
    tk(1);  chk("s1_y1", out1, 3'b010);
    tk(5);  chk("s1_ar1", out2, 3'b100);
    tk(2);  chk("s1_g2", out2, 3'b001);
    tk(15); chk("s1_y2", out2, 3'b010);
    tk(7);  chk("s1_g1b", out1, 3'b001);

    ped_req1 = 1; cyc(1); ped_req1 = 0;
    tk(3);  chk("s2_g1", out1, 3'b001);
    tk(1);  chk("s2_trunc", out1, 3'b010);
    tk(7);  chk("s2_walk_on", {2'b0, walk1}, 3'b001);
    tk(3);  chk("s2_walk_4", {2'b0, walk1}, 3'b001);
    tk(1);  chk("s2_walk_off", {2'b0, walk1}, 3'b000);
    tk(18); chk("s2_g1", out1, 3'b001);

    tk(12);
    ped_req1 = 1; cyc(0); ped_req1 = 0;
    chk("s3_g1", out1, 3'b001);
    tk(1);  chk("s3_trunc", out1, 3'b010);
    tk(7);  chk("s3_walk", {2'b0, walk1}, 3'b001);
    tk(22); chk("s3_g1", out1, 3'b001);

    tk(2);
    emerg_req = 1; emerg_dir = 1;
    tk(1);  chk("s4_y1", out1, 3'b010);
    tk(5);  chk("s4_ar1", out1, 3'b100);
    tk(2);  chk("s4_em2", out2, 3'b001);
    emerg_dir = 0;
    tk(3);  chk("s4_hold", out2, 3'b001);
    emerg_req = 0;
    cyc(0); chk("s4_y2", out2, 3'b010);
    tk(7);  chk("s4_g1", out1, 3'b001);

    tk(2);
    emerg_req = 1;
    cyc(0); chk("s5_em1", out1, 3'b001);
    tk(20); chk("s5_frozen", out1, 3'b001);
    emerg_req = 0;
    cyc(0); chk("s5_y1", out1, 3'b010);
    tk(4);  chk("s5_y1_4", out1, 3'b010);
    tk(1);  chk("s5_ar1", out1, 3'b100);
    tk(24); chk("s5_g1", out1, 3'b001);

    ped_req1 = 1; cyc(0); ped_req1 = 0;
    tk(12); chk("s6_walk", {2'b0, walk1}, 3'b001);
    tk(1);
    do_reset();
    tk(14); chk("s6_g1", out1, 3'b001);
    tk(1);  chk("s6_y1", out1, 3'b010);

    for (int i = 0; i < 4000; i++) begin
      ped_req1 = ($urandom_range(0, 29) == 0);
      ped_req2 = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 199) == 0) emerg_req = !emerg_req;
      if ($urandom_range(0, 49) == 0) emerg_dir = 1'($urandom_range(0, 1));
      if (i == 2000) do_reset();
      cyc($urandom_range(0, 2) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
